// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate-array vector sequencer.
package gate_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        CHECK,
        DONE
    } state_t;

    localparam logic [1:0] OP_OR  = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOR = 2'd3;

    localparam int ERR_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/gate_seq_check.sv
// Expected-value model of the gate array and the X-aware result comparator.
module gate_seq_check
    import gate_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_got,
    output logic [WIDTH-1:0] o_exp,
    output logic             o_mismatch
);

    // Pick the reference function the array is supposed to implement.
    always_comb begin
        o_exp = ~(i_a | i_b);
        case (i_op)
            OP_OR:   o_exp = i_a | i_b;
            OP_AND:  o_exp = i_a & i_b;
            OP_XOR:  o_exp = i_a ^ i_b;
            default: o_exp = ~(i_a | i_b);
        endcase
    end

    // Case inequality so an undriven or unknown result bit is always an error.
    assign o_mismatch = (i_got !== o_exp);

endmodule

// File: rtl/gate_vec_seq.sv
// Walking-ones sweep sequencer that drives a gate array and scores its output.
module gate_vec_seq
    import gate_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op_sel,
    output logic [WIDTH-1:0] gate_a,
    output logic [WIDTH-1:0] gate_b,
    input  logic [WIDTH-1:0] gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_exp,
    output logic [WIDTH-1:0] fail_got
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]    CNT_END = CW'(SETTLE - 1);
    localparam logic [WIDTH-1:0] A_FIRST = WIDTH'(1);
    localparam logic [WIDTH-1:0] A_LAST  = WIDTH'(1) << (WIDTH - 2);
    localparam logic [WIDTH-1:0] B_FIRST = WIDTH'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] B_LAST  = WIDTH'(1);

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_gateA;
    logic [WIDTH-1:0] r_gateB;
    logic [ERR_W-1:0] r_errCount;
    logic [WIDTH-1:0] r_failA;
    logic [WIDTH-1:0] r_failB;
    logic [WIDTH-1:0] r_failExp;
    logic [WIDTH-1:0] r_failGot;
    logic             r_pass;

    logic             w_accept;
    logic             w_checkEdge;
    logic             w_lastVec;
    logic [WIDTH-1:0] w_exp;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_errNext;

    gate_seq_check #(
        .WIDTH(WIDTH)
    ) u_check (
        .i_op      (r_op),
        .i_a       (r_gateA),
        .i_b       (r_gateB),
        .i_got     (gate_out),
        .o_exp     (w_exp),
        .o_mismatch(w_mismatch)
    );

    assign w_accept    = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_checkEdge = (r_state == CHECK);
    assign w_lastVec   = (r_gateA == A_LAST) && (r_gateB == B_LAST);
    assign w_errNext   = (w_mismatch && (r_errCount != ERR_MAX)) ?
                         r_errCount + ERR_W'(1) : r_errCount;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: one APPLY cycle, SETTLE-1 WAIT cycles, one CHECK cycle per vector.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = APPLY;
            APPLY:   w_nextState = (SETTLE == 1) ? CHECK : WAIT;
            WAIT:    if (r_cnt == CNT_END) w_nextState = CHECK;
            CHECK:   w_nextState = w_lastVec ? DONE : APPLY;
            DONE:    if (start) w_nextState = APPLY;
            default: w_nextState = IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            APPLY, WAIT, CHECK: busy = 1'b1;
            DONE:               done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Settle counter tracks how many cycles the current operands have been held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == APPLY) begin
            r_cnt <= CW'(1);
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Operand shifters, captured op, error counter and first-failure snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_gateA    <= '0;
            r_gateB    <= '0;
            r_errCount <= '0;
            r_failA    <= '0;
            r_failB    <= '0;
            r_failExp  <= '0;
            r_failGot  <= '0;
            r_pass     <= 1'b0;
        end else if (w_accept) begin
            r_op       <= op_sel;
            r_gateA    <= A_FIRST;
            r_gateB    <= B_FIRST;
            r_errCount <= '0;
            r_failA    <= '0;
            r_failB    <= '0;
            r_failExp  <= '0;
            r_failGot  <= '0;
            r_pass     <= 1'b0;
        end else if (w_checkEdge) begin
            r_errCount <= w_errNext;
            if (w_mismatch && (r_errCount == '0)) begin
                r_failA   <= r_gateA;
                r_failB   <= r_gateB;
                r_failExp <= w_exp;
                r_failGot <= gate_out;
            end
            if (w_lastVec) begin
                r_pass <= (w_errNext == '0);
            end else if (r_gateB == B_LAST) begin
                r_gateB <= B_FIRST;
                r_gateA <= r_gateA << 1;
            end else begin
                r_gateB <= r_gateB >> 1;
            end
        end
    end

    assign gate_a    = r_gateA;
    assign gate_b    = r_gateB;
    assign err_count = r_errCount;
    assign fail_a    = r_failA;
    assign fail_b    = r_failB;
    assign fail_exp  = r_failExp;
    assign fail_got  = r_failGot;
    assign pass      = r_pass;

endmodule

// File: tb/tb_gate_vec_seq.sv
// Bench for gate_vec_seq: modelled gate array, per-cycle scoreboard, directed sweeps.
module tb_gate_vec_seq;
    import gate_seq_pkg::*;

    localparam int W      = 16;
    localparam int SETTLE = 1;
    localparam int PER    = SETTLE + 1;
    localparam int NVEC   = (W - 1) * W;
    localparam int SWEEP  = NVEC * PER;
    localparam int SNAP_W = 3 + 2 * W + 16 + 4 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op_sel;
    logic [W-1:0]  gate_a;
    logic [W-1:0]  gate_b;
    logic [W-1:0]  gate_out;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   err_count;
    logic [W-1:0]  fail_a;
    logic [W-1:0]  fail_b;
    logic [W-1:0]  fail_exp;
    logic [W-1:0]  fail_got;

    int   total = 0;
    int   bad = 0;
    int   arrMode = 0;
    logic xBit = 1'bx;

    int   edgeK = -1;
    bit   tracking = 1'b0;
    bit   holdMode = 1'b0;

    int           errBefore [NVEC+1];
    int           firstIdx;
    logic [W-1:0] mFailA, mFailB, mFailExp, mFailGot;

    gate_vec_seq #(
        .WIDTH (W),
        .SETTLE(SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_sel   (op_sel),
        .gate_a   (gate_a),
        .gate_b   (gate_b),
        .gate_out (gate_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_count(err_count),
        .fail_a   (fail_a),
        .fail_b   (fail_b),
        .fail_exp (fail_exp),
        .fail_got (fail_got)
    );

    always #5 clk = ~clk;

    // Gate array under test: mode 0 ideal OR, 1 OR with bit 3 stuck low, 2 OR with bit 0 unknown.
    function automatic logic [W-1:0] arrayOut(int mode, logic [W-1:0] a, logic [W-1:0] b);
        logic [W-1:0] r;
        r = a | b;
        if (mode == 1) r[3] = 1'b0;
        else if (mode == 2) r[0] = xBit;
        return r;
    endfunction

    assign gate_out = arrayOut(arrMode, gate_a, gate_b);

    function automatic logic [W-1:0] expOf(logic [1:0] op, logic [W-1:0] a, logic [W-1:0] b);
        case (op)
            2'd0:    return a | b;
            2'd1:    return a & b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    function automatic logic [W-1:0] vecA(int v);
        return W'(1) << (v / W);
    endfunction

    function automatic logic [W-1:0] vecB(int v);
        return W'(1) << (W - 1 - (v % W));
    endfunction

    // Precompute running mismatch totals and the first failing vector for one sweep.
    task automatic buildModel(int mode, logic [1:0] op);
        logic [W-1:0] a, b, g, e;
        errBefore[0] = 0;
        firstIdx = -1;
        mFailA = '0; mFailB = '0; mFailExp = '0; mFailGot = '0;
        for (int v = 0; v < NVEC; v++) begin
            a = vecA(v);
            b = vecB(v);
            g = arrayOut(mode, a, b);
            e = expOf(op, a, b);
            errBefore[v+1] = errBefore[v] + ((g !== e) ? 1 : 0);
            if ((g !== e) && firstIdx < 0) begin
                firstIdx = v;
                mFailA = a; mFailB = b; mFailExp = e; mFailGot = g;
            end
        end
    endtask

    // Expected outputs k edges after the accept edge.
    function automatic logic [SNAP_W-1:0] modelSnap(int k);
        int v;
        logic [W-1:0] fa, fb, fe, fg;
        v = k / PER;
        if (v >= NVEC) begin
            fa = mFailA; fb = mFailB; fe = mFailExp; fg = mFailGot;
            return {1'b0, 1'b1, (errBefore[NVEC] == 0), vecA(NVEC-1), vecB(NVEC-1),
                    16'(errBefore[NVEC]), fa, fb, fe, fg};
        end
        if (firstIdx >= 0 && firstIdx < v) begin
            fa = mFailA; fb = mFailB; fe = mFailExp; fg = mFailGot;
        end else begin
            fa = '0; fb = '0; fe = '0; fg = '0;
        end
        return {1'b1, 1'b0, 1'b0, vecA(v), vecB(v), 16'(errBefore[v]), fa, fb, fe, fg};
    endfunction

    // Edge counter relative to the most recent accept edge.
    always @(posedge clk) begin
        if (tracking) edgeK <= edgeK + 1;
    end

    // Scoreboard: compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        int keff;
        logic [SNAP_W-1:0] want, got;
        if (tracking && edgeK >= 0) begin
            keff = holdMode ? (edgeK % (SWEEP + 1)) : edgeK;
            want = modelSnap(keff);
            got  = {busy, done, pass, gate_a, gate_b, err_count, fail_a, fail_b, fail_exp, fail_got};
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL cycle k=%0d got=%h want=%h", edgeK, got, want);
            end
        end
    end

    task automatic checkOutput(string name, logic [W-1:0] got, logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Run one tracked sweep; optional start pulses are injected while busy.
    task automatic applyStimulus(int mode, logic [1:0] op, bit pulses);
        int guard;
        int targets [3] = '{5, 100, SWEEP - 1};
        arrMode = mode;
        buildModel(mode, op);
        @(negedge clk);
        op_sel   = op;
        start    = 1'b1;
        holdMode = 1'b0;
        edgeK    = -1;
        tracking = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        op_sel = ~op;
        if (pulses) begin
            for (int i = 0; i < 3; i++) begin
                while (edgeK < targets[i]) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        guard = 0;
        while (edgeK < SWEEP + 3 && guard < SWEEP + 50) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (edgeK < SWEEP + 3) begin
            bad++;
            $display("[TB] FAIL sweep timeout got=%0d want=%0d", edgeK, SWEEP + 3);
        end
        tracking = 1'b0;
    endtask

    initial begin
        int guard;
        rst_n  = 1'b1;
        start  = 1'b0;
        op_sel = 2'd0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset busy", W'(busy), '0);
        checkOutput("reset done", W'(done), '0);
        checkOutput("reset pass", W'(pass), '0);
        checkOutput("reset gate_a", gate_a, '0);
        checkOutput("reset gate_b", gate_b, '0);
        checkOutput("reset err", err_count, '0);
        checkOutput("reset fail_a", fail_a, '0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] ideal OR with start pulses while busy");
        applyStimulus(0, OP_OR, 1'b1);
        checkOutput("or done", W'(done), 16'd1);
        checkOutput("or pass", W'(pass), 16'd1);
        checkOutput("or err", err_count, 16'd0);
        checkOutput("or fail_got", fail_got, 16'h0000);

        $display("[TB] OR with bit 3 stuck low");
        applyStimulus(1, OP_OR, 1'b0);
        checkOutput("stuck err", err_count, 16'd30);
        checkOutput("stuck fail_a", fail_a, 16'h0001);
        checkOutput("stuck fail_b", fail_b, 16'h0008);
        checkOutput("stuck fail_exp", fail_exp, 16'h0009);
        checkOutput("stuck fail_got", fail_got, 16'h0001);
        checkOutput("stuck pass", W'(pass), 16'd0);

        $display("[TB] ideal OR array scored as XOR");
        applyStimulus(0, OP_XOR, 1'b0);
        checkOutput("xor err", err_count, 16'd15);
        checkOutput("xor fail_a", fail_a, 16'h0001);
        checkOutput("xor fail_b", fail_b, 16'h0001);
        checkOutput("xor fail_exp", fail_exp, 16'h0000);
        checkOutput("xor fail_got", fail_got, 16'h0001);

        $display("[TB] OR with unknown bit 0");
        applyStimulus(2, OP_OR, 1'b0);
        checkOutput("xbit pass", W'(pass), 16'd0);
        if (xBit === 1'bx) checkOutput("xbit err", err_count, 16'd240);

        $display("[TB] start held high across DONE");
        arrMode = 1;
        buildModel(1, OP_OR);
        @(negedge clk);
        op_sel   = OP_OR;
        start    = 1'b1;
        holdMode = 1'b1;
        edgeK    = -1;
        tracking = 1'b1;
        while (edgeK < SWEEP) @(negedge clk);
        checkOutput("held first err", err_count, 16'd30);
        checkOutput("held first done", W'(done), 16'd1);
        while (edgeK < SWEEP + 2) @(negedge clk);
        checkOutput("held restart err", err_count, 16'd0);
        checkOutput("held restart busy", W'(busy), 16'd1);
        tracking = 1'b0;
        holdMode = 1'b0;
        start    = 1'b0;
        guard = 0;
        while (!done && guard < SWEEP + 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("held second done", W'(done), 16'd1);
        checkOutput("held second err", err_count, 16'd30);

        $display("[TB] reset in the middle of a sweep");
        arrMode = 1;
        buildModel(1, OP_OR);
        @(negedge clk);
        op_sel   = OP_OR;
        start    = 1'b1;
        edgeK    = -1;
        tracking = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (edgeK < 100) @(negedge clk);
        tracking = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort busy", W'(busy), '0);
        checkOutput("abort gate_a", gate_a, '0);
        checkOutput("abort gate_b", gate_b, '0);
        checkOutput("abort err", err_count, '0);
        checkOutput("abort fail_a", fail_a, '0);
        checkOutput("abort fail_got", fail_got, '0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, OP_OR, 1'b0);
        checkOutput("after abort pass", W'(pass), 16'd1);
        checkOutput("after abort err", err_count, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
